// File: rtl/fifo_wr_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_pkg
// Shared types and constants for the fifo_wr_arb write arbiter.
//   arb_state_e : arbiter FSM state (ST_IDLE, ST_GRANT)
//   STALL_CNT_W : width of the optional stall counter
//                 (present only when FIFO_WR_ARB_STALL_CNT_EN is defined)
// -----------------------------------------------------------------------------
package fifo_wr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned STALL_CNT_W = 16;

endpackage : fifo_wr_arb_pkg

// File: rtl/fifo_wr_arb_rr.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_rr
// Purely combinational round-robin picker. It searches the request vector
// starting at last_owner_i+1 (mod NREQ) and returns the first requester found.
// Ports:
//   req_i        [NREQ-1:0] request vector, bit k is requester k
//   last_owner_i [IDXW-1:0] previous grant owner (search starts after it)
//   valid_o                 at least one request is pending
//   index_o      [IDXW-1:0] selected requester (0 when valid_o is low)
// -----------------------------------------------------------------------------
module fifo_wr_arb_rr #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] last_owner_i,
  output logic            valid_o,
  output logic [IDXW-1:0] index_o
);

  logic [IDXW-1:0] cand;

  // Offsets run 1..NREQ so the previous owner is considered last; the first
  // hit wins because valid_o blocks later overwrites.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IDXW'((32'(last_owner_i) + off) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule : fifo_wr_arb_rr

// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
// Round-robin arbiter letting NREQ requesters write bursts of up to BURST beats
// into one shared FIFO.
// Ports:
//   i_clk          clock, rising edge
//   i_nrst         asynchronous active-low reset
//   i_req          [NREQ-1:0]       per-requester write request
//   i_data         [NREQ*WIDTH-1:0] packed data, requester k at [k*WIDTH +: WIDTH]
//   o_ack          [NREQ-1:0]       one-hot beat accepted this cycle
//   o_fifo_write                    write strobe to the shared FIFO
//   o_fifo_data    [WIDTH-1:0]      owner's data slice
//   i_fifo_full                     shared FIFO full
//   o_owner        [$clog2(NREQ)-1:0] current grant owner
//   o_busy                          high in ST_GRANT (exposes the FSM state)
//   o_stall_cnt    [15:0]           saturating count of stalled GRANT cycles;
//                                   only when FIFO_WR_ARB_STALL_CNT_EN is defined
//
// Handshake: i_req[k] is the valid of requester k; the beat transfers when
// k owns the grant and the FIFO is not full (ready). o_ack[k] marks the
// cycle the beat transfers; the requester then presents the next word or
// drops i_req. Valid is never qualified by ready.
// -----------------------------------------------------------------------------
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned BURST = 4,
  localparam int unsigned IDXW  = $clog2(NREQ),
  localparam int unsigned BW    = $clog2(BURST + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_data,
  output logic [NREQ-1:0]       o_ack,
  output logic                  o_fifo_write,
  output logic [WIDTH-1:0]      o_fifo_data,
  input  logic                  i_fifo_full,
  output logic [IDXW-1:0]       o_owner,
  output logic                  o_busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
`endif
);

  localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0]   BEAT_LAST = BW'(BURST);
  localparam logic [IDXW-1:0] LAST_RST  = IDXW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] last_q,  last_d;
  logic [BW-1:0]   beat_q,  beat_d;

  logic            rr_valid;
  logic [IDXW-1:0] rr_index;
  logic            owner_req;
  logic            wr;

  fifo_wr_arb_rr #(
    .NREQ (NREQ)
  ) u_rr (
    .req_i        (i_req),
    .last_owner_i (last_q),
    .valid_o      (rr_valid),
    .index_o      (rr_index)
  );

  assign owner_req = i_req[owner_q];
  assign wr        = (state_q == ST_GRANT) && owner_req && !i_fifo_full;

  assign o_fifo_write = wr;
  assign o_fifo_data  = i_data[32'(owner_q) * WIDTH +: WIDTH];
  assign o_owner      = owner_q;
  assign o_busy       = (state_q == ST_GRANT);

  always_comb begin
    o_ack = '0;
    if (wr) o_ack[owner_q] = 1'b1;
  end

  // Next-state: non-owner requests are not looked at while in ST_GRANT.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          owner_d = rr_index;
          beat_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else if (wr) begin
          beat_d = beat_q + BEAT_ONE;
          if (beat_q + BEAT_ONE == BEAT_LAST) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_GRANT) && owner_req && i_fifo_full && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule : fifo_wr_arb

// File: tb/tb_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb
// Directed bench for fifo_wr_arb with NREQ=4, WIDTH=8, BURST=4.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb;

  logic        i_clk;
  logic        i_nrst;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_ack;
  logic        o_fifo_write;
  logic [7:0]  o_fifo_data;
  logic        i_fifo_full;
  logic [1:0]  o_owner;
  logic        o_busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] o_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] data_tab[4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  fifo_wr_arb #(
    .NREQ  (4),
    .WIDTH (8),
    .BURST (4)
  ) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_req        (i_req),
    .i_data       (i_data),
    .o_ack        (o_ack),
    .o_fifo_write (o_fifo_write),
    .o_fifo_data  (o_fifo_data),
    .i_fifo_full  (i_fifo_full),
    .o_owner      (o_owner),
    .o_busy       (o_busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    .o_stall_cnt  (o_stall_cnt)
`endif
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the hand-computed expectation for this cycle.
  task automatic check_outputs(input string tag, input logic busy,
                               input logic [1:0] owner, input logic [3:0] ack);
    logic [7:0] exp_word;
    check({tag, "_busy"},  32'(o_busy), 32'(busy));
    check({tag, "_owner"}, 32'(o_owner), 32'(owner));
    check({tag, "_ack"},   32'(o_ack), 32'(ack));
    check({tag, "_wr"},    32'(o_fifo_write), 32'(ack != 4'b0));
    check({tag, "_data"},  32'(o_fifo_data), 32'(data_tab[owner]));
    check({tag, "_onehot"}, 32'($onehot0(o_ack)), 32'(1));
    check({tag, "_wr_or"},  32'(o_fifo_write), 32'(|o_ack));
    check({tag, "_wrfull"}, 32'(o_fifo_write & i_fifo_full), 32'(0));
    if (o_fifo_write) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_unexpected"}, 32'(1), 32'(0));
      end else begin
        exp_word = exp_q.pop_front();
        check({tag, "_sb"}, 32'(o_fifo_data), 32'(exp_word));
      end
    end
  endtask

  // driver tasks
  task automatic step(input string tag, input logic [3:0] req, input logic full,
                      input logic busy, input logic [1:0] owner, input logic [3:0] ack);
    @(negedge i_clk);
    i_req       = req;
    i_fifo_full = full;
    #1;
    check_outputs(tag, busy, owner, ack);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_nrst      = 1'b0;
    i_req       = '0;
    i_fifo_full = 1'b0;
    @(negedge i_clk);
    i_nrst = 1'b1;
  endtask

  task automatic push_n(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
  endtask

  initial begin
    logic [1:0] idle_own[5]  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] grant_own[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] ack_v;

    i_nrst      = 1'b0;
    i_req       = 4'b1111;
    i_fifo_full = 1'b0;
    i_data      = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // reset state with all requests high
    #3;
    check_outputs("rst", 1'b0, 2'd0, 4'b0000);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check("rst_stall", 32'(o_stall_cnt), 32'(0));
`endif
    @(negedge i_clk);
    i_req  = '0;
    i_nrst = 1'b1;

    // single requester: arbitrate, 4 beats, idle, re-grant
    push_n(8'hA0, 5);
    step("t1_c0", 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000);
    for (int i = 1; i <= 4; i++)
      step($sformatf("t1_c%0d", i), 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001);
    step("t1_c5", 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000);
    step("t1_c6", 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001);
    step("t1_c7", 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000);
    step("t1_c8", 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);

    // all requesting: owners 0,1,2,3,0 with an idle cycle between bursts
    do_reset();
    for (int b = 0; b < 5; b++) push_n(data_tab[grant_own[b]], 4);
    for (int b = 0; b < 5; b++) begin
      step($sformatf("t2_idle%0d", b), 4'b1111, 1'b0, 1'b0, idle_own[b], 4'b0000);
      ack_v = 4'b0001 << grant_own[b];
      for (int i = 0; i < 4; i++)
        step($sformatf("t2_b%0d_%0d", b, i), 4'b1111, 1'b0, 1'b1, grant_own[b], ack_v);
    end

    // owner 2 stalled by full for 5 cycles mid-burst
    do_reset();
    push_n(8'hC2, 4);
    step("t3_idle", 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000);
    step("t3_w1",   4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100);
    step("t3_w2",   4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100);
    for (int i = 0; i < 5; i++)
      step($sformatf("t3_full%0d", i), 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000);
    step("t3_w3",   4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100);
    step("t3_w4",   4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100);
    step("t3_end",  4'b0100, 1'b0, 1'b0, 2'd2, 4'b0000);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check("t3_stall", 32'(o_stall_cnt), 32'(5));
`endif

    // owner 1 drops its request after 2 beats; next search starts at 2
    do_reset();
    push_n(8'hB1, 2);
    push_n(8'hC2, 1);
    step("t4_idle", 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000);
    step("t4_w1",   4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010);
    step("t4_w2",   4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010);
    step("t4_drop", 4'b1101, 1'b0, 1'b1, 2'd1, 4'b0000);
    step("t4_idl2", 4'b1101, 1'b0, 1'b0, 2'd1, 4'b0000);
    step("t4_next", 4'b1101, 1'b0, 1'b1, 2'd2, 4'b0100);

    // reset pulsed during beat 3 of owner 3
    do_reset();
    push_n(8'hD3, 6);
    step("t5_idle", 4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000);
    step("t5_w1",   4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000);
    step("t5_w2",   4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000);
    @(negedge i_clk);
    i_nrst = 1'b0;
    #1;
    check_outputs("t5_rst", 1'b0, 2'd0, 4'b0000);
    @(negedge i_clk);
    i_nrst = 1'b1;
    #1;
    check_outputs("t5_rel", 1'b0, 2'd0, 4'b0000);
    for (int i = 1; i <= 4; i++)
      step($sformatf("t5_r%0d", i), 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000);
    step("t5_end",  4'b1000, 1'b0, 1'b0, 2'd3, 4'b0000);

    check("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_wr_arb

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data word width.
REQ-003 SHALL have parameter BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port i_nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_req  input  NREQ  per-requester write request; bit k is requester k.
REQ-007 SHALL have port i_data  input  NREQ*WIDTH  packed request data; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port o_ack  output  NREQ  one-hot per-requester beat accepted this cycle.
REQ-009 SHALL have port o_fifo_write  output  1  write strobe to the shared FIFO.
REQ-010 SHALL have port o_fifo_data  output  WIDTH  write data to the shared FIFO.
REQ-011 SHALL have port i_fifo_full  input  1  shared FIFO full; no write accepted when high.
REQ-012 SHALL have port o_owner  output  $clog2(NREQ)  index of the current grant owner.
REQ-013 SHALL have port o_busy  output  1  high while in GRANT state.

Function
REQ-014 SHALL implement FSM states IDLE and GRANT.
REQ-015 IDLE: if any i_req bit is high, SHALL select the first requesting index searching round-robin from last_owner+1 (mod NREQ), load owner, clear beat count, and enter GRANT next cycle (1-cycle arbitration latency).
REQ-016 IDLE: SHALL hold o_fifo_write=0 and o_ack=0.
REQ-017 GRANT: o_fifo_write SHALL equal i_req[owner] & !i_fifo_full, combinationally.
REQ-018 GRANT: o_ack[owner] SHALL equal o_fifo_write; all other o_ack bits SHALL be 0.
REQ-019 o_fifo_data SHALL equal the owner's slice of i_data at all times.
REQ-020 GRANT: each write SHALL increment the beat count; stalled cycles (full) SHALL NOT count.
REQ-021 GRANT: SHALL return to IDLE and set last_owner=owner after the write that makes beat count equal BURST, or on any cycle with i_req[owner]=0.
REQ-022 Owner SHALL keep the grant while i_fifo_full is high and i_req[owner] stays high, indefinitely.
REQ-023 Requests from non-owners during GRANT SHALL be ignored until the next IDLE.
REQ-024 Beat count SHALL be $clog2(BURST+1) bits and never exceed BURST.

Reset
REQ-025 On i_nrst low, FSM SHALL go to IDLE, owner=0, beat count=0, last_owner=NREQ-1 (requester 0 first priority).
REQ-026 During and after reset: o_fifo_write=0, o_ack=0, o_busy=0, o_owner=0, o_fifo_data = i_data slice 0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; no write SHALL occur in the reset cycle.

Configuration
REQ-028 Macro FIFO_WR_ARB_STALL_CNT_EN: when defined, SHALL add output o_stall_cnt (16 bits), reset 0, incrementing each GRANT cycle with i_req[owner]=1 and i_fifo_full=1, saturating at 16'hFFFF.
REQ-029 When FIFO_WR_ARB_STALL_CNT_EN is undefined, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, GRANT) and the stall-counter width constant (16).
REQ-031 Round-robin selection SHALL be a sub-module fifo_wr_arb_rr (inputs: request vector, last_owner; outputs: valid, index), purely combinational.

Verification
REQ-032 NREQ=4, BURST=4; req=4'b0001, full=0 for 6 cycles -> 1 arbitration cycle, 4 writes with ack[0], 1 IDLE cycle, re-grant to 0.
REQ-033 req=4'b1111 held, full=0 -> owners in order 0,1,2,3,0, each 4 beats, one IDLE cycle between bursts.
REQ-034 Owner 2 granted, full=1 for 5 cycles mid-burst -> no writes, no acks, owner stays 2, beat count unchanged; burst completes after full drops; o_stall_cnt=5 when macro defined.
REQ-035 Owner 1 drops req after 2 beats -> IDLE next cycle, next grant searches from 2.
REQ-036 i_nrst pulsed low during beat 3 of owner 3 -> outputs zero immediately; after release with req=4'b1000, requester 3 re-granted after 1 IDLE cycle, beat count from 0.
REQ-037 Check every cycle: o_ack one-hot or zero, o_fifo_write=|o_ack, never write when i_fifo_full=1.
